// File: rtl/width_convert_stream_if.sv
// width_convert_stream_if: valid/ready stream bundle for the width converter
// Ports: s_valid/s_ready/s_data/s_last (narrow or wide input side),
//        m_valid/m_ready/m_data/m_last/m_keep (output side).
// slave modport is the converter; master modport is whoever feeds and drains it.
interface width_convert_stream_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
);
  localparam int KW = OUT_WIDTH > IN_WIDTH ? OUT_WIDTH / IN_WIDTH : 1;
  logic                 s_valid, s_ready, s_last;
  logic [IN_WIDTH-1:0]  s_data;
  logic                 m_valid, m_ready, m_last;
  logic [OUT_WIDTH-1:0] m_data;
  logic [KW-1:0]        m_keep;
  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data, m_last, m_keep);
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data, m_last, m_keep);
endinterface

// File: rtl/width_convert_stream.sv
// width_convert_stream: packs narrow beats into wide words or splits wide words into narrow slices
// Ports: clk, rst_n (async, active-low), bus (width_convert_stream_if.slave).
// Lane 0 is the first beat/slice; MSB_FIRST places it in the most-significant lane.
module width_convert_stream #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter bit MSB_FIRST = 1
) (
  input logic clk,
  input logic rst_n,
  width_convert_stream_if.slave bus
);
  if ((OUT_WIDTH % IN_WIDTH != 0) && (IN_WIDTH % OUT_WIDTH != 0)) begin : g_bad
    $error("width_convert_stream: widths must be integer multiples of each other");
  end
  if (OUT_WIDTH > IN_WIDTH) begin : g_up
    localparam int R  = OUT_WIDTH / IN_WIDTH;
    localparam int CW = $clog2(R);
    logic [OUT_WIDTH-1:0] acc_q, acc_d, data_q, data_d, merged;
    logic [R-1:0]         keep_q, keep_d, fill;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 valid_q, valid_d, last_q, last_d, take, done;
    assign bus.s_ready = !valid_q || bus.m_ready;
    assign bus.m_valid = valid_q;
    assign bus.m_data  = data_q;
    assign bus.m_keep  = keep_q;
    assign bus.m_last  = last_q;
    always_comb begin
      take   = bus.s_valid && bus.s_ready;
      done   = cnt_q == CW'(R - 1) || bus.s_last;
      merged = acc_q;
      merged[(MSB_FIRST ? (R - 1 - int'(cnt_q)) * IN_WIDTH : int'(cnt_q) * IN_WIDTH) +: IN_WIDTH] = bus.s_data;
      for (int k = 0; k < R; k++) fill[k] = k <= int'(cnt_q);
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q && !bus.m_ready;
      if (take) begin
        acc_d = done ? '0 : merged;
        cnt_d = done ? '0 : cnt_q + 1'b1;
        if (done) begin
          data_d  = merged;
          keep_d  = fill;
          last_d  = bus.s_last;
          valid_d = 1'b1;
        end
      end
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
        valid_q <= valid_d;
      end
  end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
    localparam int R  = IN_WIDTH / OUT_WIDTH;
    localparam int CW = $clog2(R);
    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d, last_q, last_d, final_slice;
    // the holding register is free again exactly when its last slice leaves
    assign final_slice = cnt_q == CW'(R - 1);
    assign bus.s_ready = !valid_q || (bus.m_ready && final_slice);
    assign bus.m_valid = valid_q;
    assign bus.m_data  = hold_q[(MSB_FIRST ? (R - 1 - int'(cnt_q)) * OUT_WIDTH : int'(cnt_q) * OUT_WIDTH) +: OUT_WIDTH];
    assign bus.m_last  = last_q && final_slice;
    assign bus.m_keep  = valid_q;
    always_comb begin
      hold_d  = hold_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (valid_q && bus.m_ready) begin
        cnt_d   = final_slice ? '0 : cnt_q + 1'b1;
        valid_d = !final_slice;
      end
      if (bus.s_valid && bus.s_ready) begin
        hold_d  = bus.s_data;
        last_d  = bus.s_last;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        hold_q  <= '0;
        last_q  <= 1'b0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        last_q  <= last_d;
        cnt_q   <= cnt_d;
        valid_q <= valid_d;
      end
  end else begin : g_eq
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d, last_q, last_d, take;
    assign bus.s_ready = !valid_q || bus.m_ready;
    assign bus.m_valid = valid_q;
    assign bus.m_data  = data_q;
    assign bus.m_last  = last_q;
    assign bus.m_keep  = valid_q;
    always_comb begin
      take    = bus.s_valid && bus.s_ready;
      data_d  = take ? bus.s_data : data_q;
      last_d  = take ? bus.s_last : last_q;
      valid_d = take || (valid_q && !bus.m_ready);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        data_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        last_q  <= last_d;
        valid_q <= valid_d;
      end
  end
endmodule

// File: tb/tb_width_convert_stream.sv
// tb_width_convert_stream: directed checks of up, down and equal-width conversion
module tb_width_convert_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  width_convert_stream_if #(.IN_WIDTH(8),  .OUT_WIDTH(16)) u16_if ();
  width_convert_stream_if #(.IN_WIDTH(8),  .OUT_WIDTH(32)) u32_if ();
  width_convert_stream_if #(.IN_WIDTH(32), .OUT_WIDTH(8))  d32_if ();
  width_convert_stream_if #(.IN_WIDTH(16), .OUT_WIDTH(8))  d16_if ();
  width_convert_stream_if #(.IN_WIDTH(8),  .OUT_WIDTH(8))  e8_if ();

  width_convert_stream #(.IN_WIDTH(8),  .OUT_WIDTH(16), .MSB_FIRST(1)) u_u16 (.clk(clk), .rst_n(rst_n), .bus(u16_if));
  width_convert_stream #(.IN_WIDTH(8),  .OUT_WIDTH(32), .MSB_FIRST(0)) u_u32 (.clk(clk), .rst_n(rst_n), .bus(u32_if));
  width_convert_stream #(.IN_WIDTH(32), .OUT_WIDTH(8),  .MSB_FIRST(1)) u_d32 (.clk(clk), .rst_n(rst_n), .bus(d32_if));
  width_convert_stream #(.IN_WIDTH(16), .OUT_WIDTH(8),  .MSB_FIRST(1)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(d16_if));
  width_convert_stream #(.IN_WIDTH(8),  .OUT_WIDTH(8),  .MSB_FIRST(1)) u_e8  (.clk(clk), .rst_n(rst_n), .bus(e8_if));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  beats [6];
  logic [18:0] words [$];
  logic [18:0] exp_w [3];
  logic [8:0]  exp_q [$];
  logic [8:0]  e;
  logic [7:0]  d_exp [8];
  logic        l_exp [8];
  logic [7:0]  pd;
  logic        stalled, acc;
  int          bi, sent;

  initial begin
    u16_if.s_valid = 0; u16_if.s_data = '0; u16_if.s_last = 0; u16_if.m_ready = 1;
    u32_if.s_valid = 0; u32_if.s_data = '0; u32_if.s_last = 0; u32_if.m_ready = 1;
    d32_if.s_valid = 0; d32_if.s_data = '0; d32_if.s_last = 0; d32_if.m_ready = 1;
    d16_if.s_valid = 0; d16_if.s_data = '0; d16_if.s_last = 0; d16_if.m_ready = 1;
    e8_if.s_valid  = 0; e8_if.s_data  = '0; e8_if.s_last  = 0; e8_if.m_ready  = 1;
    #2 rst_n = 0;
    tick;
    tick;
    chk("rst_u16", {u16_if.m_valid, u16_if.m_last, u16_if.m_keep, u16_if.m_data}, 0);
    chk("rst_u32", {u32_if.m_valid, u32_if.m_last, u32_if.m_keep, u32_if.m_data}, 0);
    chk("rst_d32", {d32_if.m_valid, d32_if.m_last, d32_if.m_keep, d32_if.m_data}, 0);
    chk("rst_d16", {d16_if.m_valid, d16_if.m_last, d16_if.m_keep, d16_if.m_data}, 0);
    chk("rst_e8",  {e8_if.m_valid,  e8_if.m_last,  e8_if.m_keep,  e8_if.m_data},  0);
    rst_n = 1;
    tick;

    // up 8->16, MSB first, no backpressure
    u16_if.s_valid = 1; u16_if.s_data = 8'hAA; tick;
    chk("up16_gap0", u16_if.m_valid, 0);
    u16_if.s_data = 8'hBB; tick;
    chk("up16_w0", {u16_if.m_valid, u16_if.m_last, u16_if.m_keep, u16_if.m_data}, {1'b1, 1'b0, 2'b11, 16'hAABB});
    u16_if.s_data = 8'hCC; tick;
    chk("up16_gap1", u16_if.m_valid, 0);
    u16_if.s_data = 8'hDD; u16_if.s_last = 1; tick;
    chk("up16_w1", {u16_if.m_valid, u16_if.m_last, u16_if.m_keep, u16_if.m_data}, {1'b1, 1'b1, 2'b11, 16'hCCDD});
    u16_if.s_valid = 0; u16_if.s_last = 0; tick;
    chk("up16_idle", u16_if.m_valid, 0);

    // up 8->32, LSB first, short packet then single-lane packet then full word
    u32_if.s_valid = 1; u32_if.s_data = 8'h11; tick;
    u32_if.s_data = 8'h22; tick;
    u32_if.s_data = 8'h33; u32_if.s_last = 1; tick;
    chk("up32_short", {u32_if.m_valid, u32_if.m_last, u32_if.m_keep, u32_if.m_data}, {1'b1, 1'b1, 4'b0111, 32'h00332211});
    u32_if.s_data = 8'h44; tick;
    chk("up32_single", {u32_if.m_valid, u32_if.m_last, u32_if.m_keep, u32_if.m_data}, {1'b1, 1'b1, 4'b0001, 32'h00000044});
    u32_if.s_data = 8'hA1; u32_if.s_last = 0; tick;
    chk("up32_gap", u32_if.m_valid, 0);
    u32_if.s_data = 8'hB2; tick;
    u32_if.s_data = 8'hC3; tick;
    u32_if.s_data = 8'hD4; tick;
    chk("up32_full", {u32_if.m_valid, u32_if.m_last, u32_if.m_keep, u32_if.m_data}, {1'b1, 1'b0, 4'b1111, 32'hD4C3B2A1});
    u32_if.s_valid = 0; tick;

    // up 8->16 with the first word stalled for 5 cycles
    beats = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    bi = 0;
    for (int c = 0; c < 20; c++) begin
      u16_if.s_valid = bi < 6;
      u16_if.s_data  = bi < 6 ? beats[bi] : 8'h00;
      u16_if.s_last  = bi == 5;
      u16_if.m_ready = !(c >= 2 && c < 7);
      #1;
      if (c >= 2 && c < 7) begin
        chk("bp_hold", {u16_if.m_valid, u16_if.m_data}, {1'b1, 16'hA1B2});
        chk("bp_sready", u16_if.s_ready, 0);
      end
      if (u16_if.m_valid && u16_if.m_ready) words.push_back({u16_if.m_last, u16_if.m_keep, u16_if.m_data});
      if (u16_if.s_valid && u16_if.s_ready) bi++;
      tick;
    end
    u16_if.s_valid = 0; u16_if.s_last = 0; u16_if.m_ready = 1;
    exp_w = '{{1'b0, 2'b11, 16'hA1B2}, {1'b0, 2'b11, 16'hC3D4}, {1'b1, 2'b11, 16'hE5F6}};
    chk("bp_count", words.size(), 3);
    chk("bp_beats", bi, 6);
    for (int i = 0; i < 3 && i < words.size(); i++) chk("bp_word", words[i], exp_w[i]);

    // down 32->8, MSB first, back-to-back words
    d_exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    l_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    d32_if.s_valid = 1; d32_if.s_data = 32'h12345678; d32_if.s_last = 1; tick;
    d32_if.s_data = 32'h9ABCDEF0;
    for (int c = 0; c < 8; c++) begin
      chk("dn32_slice", {d32_if.m_valid, d32_if.m_last, d32_if.m_data}, {1'b1, l_exp[c], d_exp[c]});
      chk("dn32_sready", d32_if.s_ready, c % 4 == 3);
      acc = d32_if.s_valid && d32_if.s_ready;
      tick;
      if (acc) d32_if.s_valid = 0;
    end
    chk("dn32_idle", d32_if.m_valid, 0);

    // down 16->8 with random backpressure against a scoreboard
    sent = 0; stalled = 0; pd = '0;
    for (int c = 0; c < 5000 && !(sent == 200 && exp_q.size() == 0); c++) begin
      if (!d16_if.s_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
        d16_if.s_valid = 1;
        d16_if.s_data  = 16'($urandom);
        d16_if.s_last  = $urandom_range(0, 2) == 0;
      end
      d16_if.m_ready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) chk("rnd_stall", {d16_if.m_valid, d16_if.m_data}, {1'b1, pd});
      if (d16_if.m_valid && d16_if.m_ready) begin
        if (exp_q.size() == 0) chk("rnd_extra", d16_if.m_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_slice", {d16_if.m_last, d16_if.m_data}, e);
        end
      end
      stalled = d16_if.m_valid && !d16_if.m_ready;
      pd = d16_if.m_data;
      acc = d16_if.s_valid && d16_if.s_ready;
      if (acc) begin
        exp_q.push_back({1'b0, d16_if.s_data[15:8]});
        exp_q.push_back({d16_if.s_last, d16_if.s_data[7:0]});
        sent++;
      end
      tick;
      if (acc) d16_if.s_valid = 0;
    end
    chk("rnd_sent", sent, 200);
    chk("rnd_drain", exp_q.size(), 0);
    d16_if.s_valid = 0; d16_if.m_ready = 1;

    // reset in the middle of a partial 8->16 word
    u16_if.s_valid = 1; u16_if.s_data = 8'h55; tick;
    u16_if.s_valid = 0; rst_n = 0;
    tick;
    rst_n = 1;
    u16_if.s_valid = 1; u16_if.s_data = 8'h01; tick;
    chk("rst_nofrag", u16_if.m_valid, 0);
    u16_if.s_data = 8'h02; tick;
    chk("rst_word", {u16_if.m_valid, u16_if.m_last, u16_if.m_keep, u16_if.m_data}, {1'b1, 1'b0, 2'b11, 16'h0102});
    u16_if.s_valid = 0; tick;

    // equal width register slice
    e8_if.m_ready = 0; e8_if.s_valid = 1; e8_if.s_data = 8'h3C; e8_if.s_last = 1; tick;
    chk("eq_word", {e8_if.m_valid, e8_if.m_last, e8_if.m_keep, e8_if.m_data}, {1'b1, 1'b1, 1'b1, 8'h3C});
    chk("eq_sready", e8_if.s_ready, 0);
    e8_if.s_data = 8'h4D; e8_if.s_last = 0; tick;
    chk("eq_hold", e8_if.m_data, 8'h3C);
    e8_if.m_ready = 1; tick;
    chk("eq_next", {e8_if.m_valid, e8_if.m_last, e8_if.m_data}, {1'b1, 1'b0, 8'h4D});
    e8_if.s_valid = 0; tick;
    chk("eq_idle", e8_if.m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
